// File: rtl/hub75_rx_if.sv
// HUB75 panel pins plus the reassembled row record, bundled so a pattern
// driver (master) and the receiver (slave) can be wired up with one connection.
interface hub75_rx_if #(
   parameter int WIDTH  = 64,
   parameter int ADDR_W = 5
);
   logic A, B, C, D, E;
   logic CLK;
   logic R1, G1, B1, R2, G2, B2;
   logic OE;
   logic LAT;

   // Row record: row_valid is a single-cycle strobe with no ready; the
   // consumer must take every field in the cycle row_valid is high.
   logic                        row_valid;
   logic [ADDR_W-1:0]           row_addr;
   logic [WIDTH-1:0]            row_r1, row_g1, row_b1;
   logic [WIDTH-1:0]            row_r2, row_g2, row_b2;
   logic [$clog2(WIDTH+2)-1:0]  row_bits;
   logic                        row_err;
   logic                        frame_start;
   logic [15:0]                 frame_count;
   logic                        panel_on;

   modport master (
      output A, B, C, D, E, CLK, R1, G1, B1, R2, G2, B2, OE, LAT,
      input  row_valid, row_addr, row_r1, row_g1, row_b1, row_r2, row_g2,
             row_b2, row_bits, row_err, frame_start, frame_count, panel_on
   );

   modport slave (
      input  A, B, C, D, E, CLK, R1, G1, B1, R2, G2, B2, OE, LAT,
      output row_valid, row_addr, row_r1, row_g1, row_b1, row_r2, row_g2,
             row_b2, row_bits, row_err, frame_start, frame_count, panel_on
   );
endinterface

// File: rtl/hub75_rx.sv
// HUB75 receiver: oversamples the panel pins, reassembles each shifted row
// into parallel colour words and emits one record per latch event.
module hub75_rx #(
   parameter int WIDTH            = 64,
   parameter int ADDR_W           = 5,
   parameter bit LATCH_BOTH_EDGES = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   hub75_rx_if.slave   bus
);

   localparam int CW    = $clog2(WIDTH+2);
   localparam int NPIN  = 14;
   localparam int CLK_I = 5;
   localparam int DAT_I = 6;
   localparam int OE_I  = 12;
   localparam int LAT_I = 13;

   // OE resets high so the panel is treated as dark until real levels arrive.
   localparam logic [NPIN-1:0] SYNC_RST = NPIN'(1) << OE_I;

   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

   logic [NPIN-1:0] pins_raw;
   logic [NPIN-1:0] sync1;
   logic [NPIN-1:0] sync2;
   logic            clk_hist;
   logic            lat_hist;

   logic            clk_rise;
   logic            lat_rise;
   logic            lat_event;
   logic            shift_en;
   logic [5:0]      data_s;
   logic [4:0]      addr_full;
   logic [ADDR_W-1:0] addr_s;

   logic [5:0][WIDTH-1:0] acc;
   logic [5:0][WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]      bit_mask;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_next;

   logic                  row_valid_q;
   logic [ADDR_W-1:0]     row_addr_q;
   logic [5:0][WIDTH-1:0] row_word_q;
   logic [CW-1:0]         row_bits_q;
   logic                  row_err_q;
   logic                  frame_start_q;
   logic [15:0]           frame_count_q;

   assign pins_raw = {bus.LAT, bus.OE,
                      bus.B2, bus.G2, bus.R2, bus.B1, bus.G1, bus.R1,
                      bus.CLK,
                      bus.E, bus.D, bus.C, bus.B, bus.A};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= SYNC_RST;
         sync2    <= SYNC_RST;
         clk_hist <= 1'b0;
         lat_hist <= 1'b0;
      end else begin
         sync1    <= pins_raw;
         sync2    <= sync1;
         clk_hist <= sync2[CLK_I];
         lat_hist <= sync2[LAT_I];
      end
   end

   assign clk_rise  = sync2[CLK_I] & ~clk_hist;
   assign lat_rise  = sync2[LAT_I] & ~lat_hist;
   assign lat_event = LATCH_BOTH_EDGES ? (sync2[LAT_I] ^ lat_hist) : lat_rise;
   assign data_s    = sync2[DAT_I +: 6];
   assign addr_full = sync2[4:0];
   assign addr_s    = addr_full[ADDR_W-1:0];

   assign shift_en  = clk_rise && (cnt < CNT_FULL);
   assign bit_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << cnt;

   // acc_next/cnt_next already include a bit shifted this cycle, so a latch
   // coinciding with a CLK rise emits the row including that final bit.
   always_comb begin
      acc_next = acc;
      for (int i = 0; i < 6; i++) begin
         acc_next[i] = acc[i] | ({WIDTH{data_s[i] & shift_en}} & bit_mask);
      end
   end

   always_comb begin
      cnt_next = cnt;
      if (clk_rise && (cnt != CNT_SAT)) begin
         cnt_next = cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc           <= '0;
         cnt           <= '0;
         row_valid_q   <= 1'b0;
         row_addr_q    <= '0;
         row_word_q    <= '0;
         row_bits_q    <= '0;
         row_err_q     <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         row_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         if (lat_event) begin
            row_valid_q <= 1'b1;
            row_word_q  <= acc_next;
            row_addr_q  <= addr_s;
            row_bits_q  <= cnt_next;
            row_err_q   <= (cnt_next != CNT_FULL);
            // row_addr_q doubles as the previous latched address; it resets
            // to 0 so the first row can never look like a wrap.
            if (addr_s < row_addr_q) begin
               frame_start_q <= 1'b1;
               frame_count_q <= frame_count_q + 16'd1;
            end
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= acc_next;
            cnt <= cnt_next;
         end
      end
   end

   assign bus.row_valid   = row_valid_q;
   assign bus.row_addr    = row_addr_q;
   assign bus.row_r1      = row_word_q[0];
   assign bus.row_g1      = row_word_q[1];
   assign bus.row_b1      = row_word_q[2];
   assign bus.row_r2      = row_word_q[3];
   assign bus.row_g2      = row_word_q[4];
   assign bus.row_b2      = row_word_q[5];
   assign bus.row_bits    = row_bits_q;
   assign bus.row_err     = row_err_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_count = frame_count_q;
   assign bus.panel_on    = ~sync2[OE_I];

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: a table of rows checked against hand-computed records,
// plus sequences for latch-edge mode, OE tracking and mid-row reset.
module tb_hub75_rx;

   logic clock;
   logic reset_n;

   hub75_rx_if #(.WIDTH(64), .ADDR_W(5)) if0 ();
   hub75_rx_if #(.WIDTH(64), .ADDR_W(5)) if1 ();

   hub75_rx #(.WIDTH(64), .ADDR_W(5), .LATCH_BOTH_EDGES(1'b0)) dut0 (
      .clock(clock), .reset_n(reset_n), .bus(if0.slave));
   hub75_rx #(.WIDTH(64), .ADDR_W(5), .LATCH_BOTH_EDGES(1'b1)) dut1 (
      .clock(clock), .reset_n(reset_n), .bus(if1.slave));

   // Both receivers watch the same pins.
   assign if1.A = if0.A;  assign if1.B = if0.B;  assign if1.C = if0.C;
   assign if1.D = if0.D;  assign if1.E = if0.E;  assign if1.CLK = if0.CLK;
   assign if1.R1 = if0.R1; assign if1.G1 = if0.G1; assign if1.B1 = if0.B1;
   assign if1.R2 = if0.R2; assign if1.G2 = if0.G2; assign if1.B2 = if0.B2;
   assign if1.OE = if0.OE; assign if1.LAT = if0.LAT;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef logic [5:0][63:0] words_t;

   typedef struct {
      logic [4:0]  addr;
      int          nbits;
      words_t      din;
      words_t      exp_w;
      logic [63:0] exp_bits;
      logic        exp_err;
      logic        exp_fs;
      logic [15:0] exp_fc;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      words_t      w;
      logic [6:0]  bits;
      logic        err;
      logic        fs;
      logic [15:0] fc;
   } rec_t;

   int   total = 0;
   int   bad   = 0;
   rec_t rec0, rec1;
   int   np0, np1;
   vec_t vt [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic words_t pk(input logic [63:0] r1, g1, b1, r2, g2, b2);
      return {b2, g2, r2, b1, g1, r1};
   endfunction

   function automatic vec_t mk(input logic [4:0] a, input int n, input words_t d,
                               input words_t e, input logic [63:0] eb,
                               input logic ee, input logic efs, input logic [15:0] efc);
      vec_t v;
      v.addr = a; v.nbits = n; v.din = d; v.exp_w = e;
      v.exp_bits = eb; v.exp_err = ee; v.exp_fs = efs; v.exp_fc = efc;
      return v;
   endfunction

   // Watch both receivers for n cycles, counting row_valid cycles and keeping
   // the last record each presented.
   task automatic observe(input int n);
      np0 = 0; np1 = 0;
      rec0 = '{default: '0};
      rec1 = '{default: '0};
      repeat (n) begin
         @(negedge clock);
         if (if0.row_valid) begin
            np0++;
            rec0.addr = if0.row_addr; rec0.bits = if0.row_bits; rec0.err = if0.row_err;
            rec0.fs = if0.frame_start; rec0.fc = if0.frame_count;
            rec0.w = {if0.row_b2, if0.row_g2, if0.row_r2, if0.row_b1, if0.row_g1, if0.row_r1};
         end
         if (if1.row_valid) begin
            np1++;
            rec1.addr = if1.row_addr; rec1.bits = if1.row_bits; rec1.err = if1.row_err;
            rec1.fs = if1.frame_start; rec1.fc = if1.frame_count;
            rec1.w = {if1.row_b2, if1.row_g2, if1.row_r2, if1.row_b1, if1.row_g1, if1.row_r1};
         end
      end
   endtask

   task automatic shift_row(input logic [4:0] a, input int n, input words_t din);
      words_t d;
      d = din;
      {if0.E, if0.D, if0.C, if0.B, if0.A} = a;
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         {if0.B2, if0.G2, if0.R2, if0.B1, if0.G1, if0.R1} =
            {d[5][0], d[4][0], d[3][0], d[2][0], d[1][0], d[0][0]};
         for (int c = 0; c < 6; c++) d[c] = d[c] >> 1;
         @(negedge clock);
         if0.CLK = 1'b1;
         repeat (2) @(negedge clock);
         if0.CLK = 1'b0;
      end
      @(negedge clock);
   endtask

   task automatic chk_words(input string name, input words_t act, input words_t exp);
      for (int c = 0; c < 6; c++) chk($sformatf("%s_w%0d", name, c), act[c], exp[c]);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, {63'd0, if0.row_valid}, 64'd0);
      chk({tag, "_addr"},  {59'd0, if0.row_addr}, 64'd0);
      chk_words({tag, "_word"}, {if0.row_b2, if0.row_g2, if0.row_r2, if0.row_b1,
                                 if0.row_g1, if0.row_r1}, '0);
      chk({tag, "_bits"},  {57'd0, if0.row_bits}, 64'd0);
      chk({tag, "_err"},   {63'd0, if0.row_err}, 64'd0);
      chk({tag, "_fs"},    {63'd0, if0.frame_start}, 64'd0);
      chk({tag, "_fc"},    {48'd0, if0.frame_count}, 64'd0);
      chk({tag, "_pon"},   {63'd0, if0.panel_on}, 64'd0);
   endtask

   words_t wa, wb, wc, wd;

   initial begin
      vt[0] = mk(5'd5, 64, pk(64'h5555_5555_5555_5555, 0, 0, 0, '1, 0),
                 pk(64'h5555_5555_5555_5555, 0, 0, 0, '1, 0), 64, 0, 0, 0);
      vt[1] = mk(5'd6, 10, pk(0, 0, 64'h3FF, 0, 0, 0),
                 pk(0, 0, 64'h3FF, 0, 0, 0), 10, 1, 0, 0);
      vt[2] = mk(5'd7, 64, pk(64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 64'hDEAD_BEEF_CAFE_F00D),
                 pk(64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 64'hDEAD_BEEF_CAFE_F00D), 64, 0, 0, 0);
      vt[3] = mk(5'd8, 70, pk(0, 0, 0, 64'h1, 0, 0),
                 pk(0, 0, 0, 64'h1, 0, 0), 65, 1, 0, 0);
      vt[4] = mk(5'd30, 64, pk(64'hF0F0_F0F0_0000_FFFF, 0, 0, 0, 0, 64'h8000_0000_0000_0001),
                 pk(64'hF0F0_F0F0_0000_FFFF, 0, 0, 0, 0, 64'h8000_0000_0000_0001), 64, 0, 0, 0);
      vt[5] = mk(5'd31, 64, pk(0, 64'hFFFF_0000_FFFF_0000, 0, 0, 0, 0),
                 pk(0, 64'hFFFF_0000_FFFF_0000, 0, 0, 0, 0), 64, 0, 0, 0);
      vt[6] = mk(5'd0, 64, pk(0, 0, 64'h1234_5678_9ABC_DEF0, 0, 0, 0),
                 pk(0, 0, 64'h1234_5678_9ABC_DEF0, 0, 0, 0), 64, 0, 1, 1);
      vt[7] = mk(5'd1, 64, pk(0, 0, 0, 0, 64'hAAAA_0000_5555_FFFF, 0),
                 pk(0, 0, 0, 0, 64'hAAAA_0000_5555_FFFF, 0), 64, 0, 0, 1);

      reset_n = 1'b0;
      {if0.A, if0.B, if0.C, if0.D, if0.E, if0.CLK, if0.LAT} = '0;
      {if0.R1, if0.G1, if0.B1, if0.R2, if0.G2, if0.B2} = '0;
      if0.OE = 1'b1;
      repeat (3) @(negedge clock);
      chk_reset_outputs("rst");
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      for (int i = 0; i < 8; i++) begin
         shift_row(vt[i].addr, vt[i].nbits, vt[i].din);
         if0.LAT = 1'b1;
         observe(6);
         chk($sformatf("v%0d_pulses", i), 64'(np0), 64'd1);
         chk($sformatf("v%0d_addr", i), {59'd0, rec0.addr}, {59'd0, vt[i].addr});
         chk_words($sformatf("v%0d", i), rec0.w, vt[i].exp_w);
         chk($sformatf("v%0d_bits", i), {57'd0, rec0.bits}, vt[i].exp_bits);
         chk($sformatf("v%0d_err", i), {63'd0, rec0.err}, {63'd0, vt[i].exp_err});
         chk($sformatf("v%0d_fs", i), {63'd0, rec0.fs}, {63'd0, vt[i].exp_fs});
         chk($sformatf("v%0d_fc", i), {48'd0, rec0.fc}, {48'd0, vt[i].exp_fc});
         if0.LAT = 1'b0;
         observe(4);
         chk($sformatf("v%0d_fall_quiet", i), 64'(np0), 64'd0);
      end

      // Latch-edge mode: row A latched on a rise, row B on the following fall.
      wa = pk(64'hA5A5_A5A5_A5A5_A5A5, 64'h0000_0000_FFFF_FFFF, 0, 0, 0, 0);
      wb = pk(64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 64'h8000_0000_0000_0000, 0, 0);
      wc = pk(64'h1, 0, 0, 0, 0, 0);
      shift_row(5'd3, 64, wa);
      if0.LAT = 1'b1;
      observe(6);
      chk("lbe_a_p0", 64'(np0), 64'd1);
      chk("lbe_a_p1", 64'(np1), 64'd1);
      chk_words("lbe_a_d0", rec0.w, wa);
      chk_words("lbe_a_d1", rec1.w, wa);
      chk("lbe_a_bits1", {57'd0, rec1.bits}, 64'd64);
      shift_row(5'd4, 64, wb);
      if0.LAT = 1'b0;
      observe(6);
      chk("lbe_b_p0", 64'(np0), 64'd0);
      chk("lbe_b_p1", 64'(np1), 64'd1);
      chk_words("lbe_b_d1", rec1.w, wb);
      chk("lbe_b_addr1", {59'd0, rec1.addr}, 64'd4);
      chk("lbe_b_bits1", {57'd0, rec1.bits}, 64'd64);
      chk("lbe_b_err1", {63'd0, rec1.err}, 64'd0);
      shift_row(5'd2, 1, wc);
      if0.LAT = 1'b1;
      observe(6);
      chk("lbe_c_p0", 64'(np0), 64'd1);
      chk_words("lbe_c_merge0", rec0.w, wb);
      chk("lbe_c_bits0", {57'd0, rec0.bits}, 64'd65);
      chk("lbe_c_err0", {63'd0, rec0.err}, 64'd1);
      chk("lbe_c_p1", 64'(np1), 64'd1);
      chk("lbe_c_bits1", {57'd0, rec1.bits}, 64'd1);
      if0.LAT = 1'b0;
      observe(4);

      // OE low reaches panel_on after two clock edges.
      chk("pon_before", {63'd0, if0.panel_on}, 64'd0);
      if0.OE = 1'b0;
      @(negedge clock);
      chk("pon_1cyc", {63'd0, if0.panel_on}, 64'd0);
      @(negedge clock);
      chk("pon_2cyc", {63'd0, if0.panel_on}, 64'd1);

      // Reset in the middle of a row throws the partial row away.
      shift_row(5'd11, 20, pk('1, '1, '1, '1, '1, '1));
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("mid");
      @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      chk("pon_after_rst", {63'd0, if0.panel_on}, 64'd1);
      wd = pk(64'hFEDC_BA98_7654_3210, 0, 64'h0000_0001_0000_0001, 0, 0, 64'h00FF_00FF_00FF_00FF);
      shift_row(5'd9, 64, wd);
      if0.LAT = 1'b1;
      observe(6);
      chk("post_p0", 64'(np0), 64'd1);
      chk_words("post", rec0.w, wd);
      chk("post_addr", {59'd0, rec0.addr}, 64'd9);
      chk("post_bits", {57'd0, rec0.bits}, 64'd64);
      chk("post_err", {63'd0, rec0.err}, 64'd0);
      chk("post_fc", {48'd0, rec0.fc}, 64'd0);
      if0.LAT = 1'b0;
      observe(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
